// File: rtl/serial_to_para_if.sv
// Handshake bundle for serial_to_para: word input side, block output side and
// the synchronous clear.
interface serial_to_para_if;
   logic         clear;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  in_word;
   logic         block_valid;
   logic         block_ready;
   logic [511:0] block;
   logic [3:0]   word_cnt;

   modport master (
      output clear, in_valid, in_word, block_ready,
      input  in_ready, block_valid, block, word_cnt
   );

   modport slave (
      input  clear, in_valid, in_word, block_ready,
      output in_ready, block_valid, block, word_cnt
   );
endinterface

// File: rtl/serial_to_para.sv
// Packs 16 32-bit message words into a 512-bit SHA-256 block (word 0 in the MSBs).
// Optional SERIAL_TO_PARA_BYPASS_EN lets the first word of the next block enter in the consume cycle.
module serial_to_para (
   input  logic              clk,
   input  logic              rst,
   serial_to_para_if.slave   bus
);

   localparam logic [0:0] COLLECT = 1'b0;
   localparam logic [0:0] FULL    = 1'b1;

   logic [0:0]   state;
   logic [3:0]   cnt_q;
   logic [511:0] block_q;
   logic [8:0]   slot_lsb;
   logic         accept;
   logic         consume;

   // Slot k occupies [511-32k -: 32], whose LSB is 32*(15-k).
   assign slot_lsb = {~cnt_q, 5'd0};
   assign consume  = (state == FULL) && bus.block_ready;

`ifdef SERIAL_TO_PARA_BYPASS_EN
   assign bus.in_ready = (state == COLLECT) || consume;
`else
   assign bus.in_ready = (state == COLLECT);
`endif

   assign accept          = bus.in_valid && bus.in_ready;
   assign bus.block_valid = (state == FULL);
   assign bus.block       = block_q;
   assign bus.word_cnt    = cnt_q;

   // In FULL the counter is 0, so a bypass accept lands in slot 0 via the same path.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= COLLECT;
         cnt_q   <= '0;
         block_q <= '0;
      end else if (bus.clear) begin
         state <= COLLECT;
         cnt_q <= '0;
      end else begin
         if (accept) begin
            block_q[slot_lsb +: 32] <= bus.in_word;
            cnt_q                   <= cnt_q + 4'd1;
         end
         case (state)
            COLLECT: if (accept && (cnt_q == 4'd15)) state <= FULL;
            FULL:    if (consume) state <= COLLECT;
            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_to_para.sv
// Directed bench for serial_to_para; follows SERIAL_TO_PARA_BYPASS_EN when defined.
module tb_serial_to_para;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [511:0] exp_blk;
   logic [511:0] held;

   serial_to_para_if bus ();

   serial_to_para dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_slot(input int unsigned k, input logic [31:0] w);
      exp_blk[511 - 32*k -: 32] = w;
   endtask

   task automatic send_block(input logic [31:0] base, input string tag);
      for (int unsigned k = 0; k < 16; k++) begin
         bus.in_valid = 1'b1;
         bus.in_word  = base + k;
         set_slot(k, base + k);
         tick();
         check({tag, "_cnt"}, bus.word_cnt, (k + 1) % 16);
         check({tag, "_bv"}, bus.block_valid, (k == 15));
      end
      bus.in_valid = 1'b0;
      check({tag, "_blk"}, bus.block, exp_blk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned k;
      int unsigned cyc;
      int unsigned nrise;
      int unsigned rise [2];
      logic        prev_bv;
      logic        offered;

      checks = 0;
      errors = 0;
      exp_blk = '0;
      rst = 1'b1;
      bus.clear = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_word = '0;
      bus.block_ready = 1'b0;
      #1;
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_bv", bus.block_valid, 1'b0);
      check("rst_cnt", bus.word_cnt, 4'd0);
      check("rst_blk", bus.block, '0);
      tick();
      tick();
      rst = 1'b0;

      // 0..15 back to back
      send_block(32'h0, "seq");
      check("seq_w0", bus.block[511:480], 32'h0);
      check("seq_w15", bus.block[31:0], 32'hF);

      // hold full block with a pending word
      held = bus.block;
      bus.in_valid = 1'b1;
      bus.in_word  = 32'hDEADBEEF;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_in_ready", bus.in_ready, 1'b0);
         check("hold_blk", bus.block, held);
         check("hold_bv", bus.block_valid, 1'b1);
      end
      bus.block_ready = 1'b1;
      #1;
      set_slot(0, 32'hDEADBEEF);
`ifdef SERIAL_TO_PARA_BYPASS_EN
      check("byp_in_ready", bus.in_ready, 1'b1);
      tick();
      bus.block_ready = 1'b0;
      check("byp_bv", bus.block_valid, 1'b0);
      check("byp_cnt", bus.word_cnt, 4'd1);
      check("byp_blk", bus.block, exp_blk);
`else
      check("cons_in_ready", bus.in_ready, 1'b0);
      tick();
      bus.block_ready = 1'b0;
      check("cons_bv", bus.block_valid, 1'b0);
      check("cons_cnt", bus.word_cnt, 4'd0);
      check("cons_blk", bus.block, held);
      tick();
      check("bubble_cnt", bus.word_cnt, 4'd1);
      check("bubble_blk", bus.block, exp_blk);
`endif
      bus.in_valid = 1'b0;

      // 7 words then clear with a word offered
      for (int unsigned j = 1; j < 8; j++) begin
         bus.in_valid = 1'b1;
         bus.in_word  = 32'hA5A5A5A5;
         set_slot(j, 32'hA5A5A5A5);
         tick();
      end
      check("a5_cnt", bus.word_cnt, 4'd8);
      bus.clear   = 1'b1;
      bus.in_word = 32'h12345678;
      tick();
      bus.clear = 1'b0;
      bus.in_valid = 1'b0;
      check("clr_cnt", bus.word_cnt, 4'd0);
      check("clr_blk", bus.block, exp_blk);
      send_block(32'h1, "post_clr");
      check("pc_w0", bus.block[511:480], 32'h1);
      check("pc_w15", bus.block[31:0], 32'h10);
      bus.block_ready = 1'b1;
      tick();
      bus.block_ready = 1'b0;
      check("pc_consumed", bus.block_valid, 1'b0);

      // random gaps on in_valid
      k = 0;
      cyc = 0;
      while (k < 16 && cyc < 200) begin
         offered = 1'($urandom_range(0, 1));
         bus.in_valid = offered;
         bus.in_word  = 32'hC0DE0000 + k;
         tick();
         cyc++;
         if (offered) begin
            set_slot(k, 32'hC0DE0000 + k);
            k++;
         end
         check("gap_cnt", bus.word_cnt, k % 16);
      end
      bus.in_valid = 1'b0;
      check("gap_bv", bus.block_valid, 1'b1);
      check("gap_blk", bus.block, exp_blk);

      // clear beats a simultaneous consume
      bus.clear = 1'b1;
      bus.block_ready = 1'b1;
      tick();
      bus.clear = 1'b0;
      bus.block_ready = 1'b0;
      check("clrfull_bv", bus.block_valid, 1'b0);
      check("clrfull_blk", bus.block, exp_blk);

      // asynchronous reset after 9 words
      for (int unsigned j = 0; j < 9; j++) begin
         bus.in_valid = 1'b1;
         bus.in_word  = 32'h900 + j;
         tick();
      end
      bus.in_valid = 1'b0;
      check("pre_arst_cnt", bus.word_cnt, 4'd9);
      #2;
      rst = 1'b1;
      #1;
      check("arst_cnt", bus.word_cnt, 4'd0);
      check("arst_bv", bus.block_valid, 1'b0);
      check("arst_blk", bus.block, '0);
      check("arst_in_ready", bus.in_ready, 1'b1);
      #2;
      rst = 1'b0;
      tick();
      exp_blk = '0;
      send_block(32'h700, "post_arst");
      bus.block_ready = 1'b1;
      tick();
      bus.block_ready = 1'b0;

      // throughput with block_ready tied high
      nrise = 0;
      rise[0] = 0;
      rise[1] = 0;
      prev_bv = bus.block_valid;
      for (int unsigned c = 0; c < 80; c++) begin
         bus.in_valid = 1'b1;
         bus.block_ready = 1'b1;
         bus.in_word = 32'hB0000000 + c;
         tick();
         if (bus.block_valid && !prev_bv && nrise < 2) begin
            rise[nrise] = c;
            nrise++;
         end
         prev_bv = bus.block_valid;
      end
      bus.in_valid = 1'b0;
      bus.block_ready = 1'b0;
      check("tp_rises", nrise, 2);
`ifdef SERIAL_TO_PARA_BYPASS_EN
      check("tp_spacing", rise[1] - rise[0], 16);
`else
      check("tp_spacing", rise[1] - rise[0], 17);
`endif
      check("tp_first", rise[0], 15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
